// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: mode encoding and start patterns shared by the LED mode controller.
package led_ctrl_pkg;
    typedef enum logic [1:0] {
        MODE_SCAN  = 2'd0,
        MODE_FILL  = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_OFF   = 2'd3
    } mode_t;
    localparam logic [7:0] SCAN_START = 8'h01;
    localparam logic [7:0] FILL_START = 8'h01;
    localparam logic [7:0] BLINK_A    = 8'h55;
    localparam logic [7:0] BLINK_B    = 8'hAA;
    localparam logic [7:0] LEDS_OFF   = 8'h00;
    function automatic logic [7:0] start_pattern(input mode_t m);
        return m == MODE_SCAN ? SCAN_START : m == MODE_FILL ? FILL_START : m == MODE_BLINK ? BLINK_A : LEDS_OFF;
    endfunction
endpackage

// File: rtl/led_mode_ctrl_tick_gen.sv
// tick_gen: free-running 0..TICK_DIV-1 divider; tick is high while the count sits at its last value.
module tick_gen #(
    parameter int TICK_DIV = 1500000
) (
    input  logic CLK12M,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge CLK12M) begin
        if (reset || clr || r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end
    assign tick = r_cnt == LAST;
    if (TICK_DIV < 2 || TICK_DIV > (1 << 24)) begin : g_bad_div
        $error("tick_gen: TICK_DIV out of range");
    end
endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: push-button selected LED pattern generator (SCAN, FILL, BLINK, OFF).
// Define USER_BTN_DEBOUNCE_EN to filter USER_BTN through a DEBOUNCE_CYCLES stable-level debouncer.
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int TICK_DIV        = 1500000,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic       CLK12M,
    input  logic       reset,
    input  logic       USER_BTN,
    output logic [7:0] LEDS,
    output logic [1:0] mode,
    output logic       step
);
    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic       r_armed;
    logic [1:0] r_vld;
    logic       w_filt;
    logic       w_press;
    logic       w_tick;
    mode_t      r_mode;
    mode_t      w_mode_nxt;
    logic [7:0] r_leds;
    logic [7:0] w_leds_nxt;
    logic [7:0] w_scan;
    logic       r_up;
    logic       w_up_nxt;

    // A press only counts once the button has been seen released since reset.
    always_ff @(posedge CLK12M) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_armed <= 1'b0;
            r_vld   <= '0;
        end else begin
            r_sync1 <= USER_BTN;
            r_sync2 <= r_sync1;
            r_prev  <= w_filt;
            r_vld   <= {r_vld[0], 1'b1};
            r_armed <= r_armed | (r_vld[1] & r_sync2);
        end
    end

`ifdef USER_BTN_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    logic [DW-1:0] r_db_cnt;
    logic          r_filt;
    always_ff @(posedge CLK12M) begin
        if (reset) begin
            r_filt   <= 1'b1;
            r_db_cnt <= '0;
        end else if (r_sync2 == r_filt) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_filt   <= r_sync2;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end
    assign w_filt = r_filt;
`else
    assign w_filt = r_sync2;
`endif

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_db
        $error("led_mode_ctrl: DEBOUNCE_CYCLES out of range");
    end

    assign w_press = r_armed & r_prev & ~w_filt;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLK12M (CLK12M),
        .reset  (reset),
        .clr    (w_press),
        .tick   (w_tick)
    );

    always_comb begin
        w_scan     = r_up ? {r_leds[6:0], 1'b0} : {1'b0, r_leds[7:1]};
        w_mode_nxt = r_mode;
        w_leds_nxt = r_leds;
        w_up_nxt   = r_up;
        if (w_press) begin
            w_mode_nxt = mode_t'(r_mode + 2'd1);
            w_leds_nxt = start_pattern(w_mode_nxt);
            w_up_nxt   = 1'b1;
        end else if (w_tick) begin
            case (r_mode)
                MODE_SCAN: begin
                    w_leds_nxt = w_scan;
                    w_up_nxt   = r_up ? w_scan != 8'h80 : w_scan == 8'h01;
                end
                MODE_FILL:  w_leds_nxt = r_leds == 8'hFF ? 8'h00 : {r_leds[6:0], 1'b1};
                MODE_BLINK: w_leds_nxt = r_leds == BLINK_A ? BLINK_B : BLINK_A;
                default:    w_leds_nxt = r_leds;
            endcase
        end
    end

    always_ff @(posedge CLK12M) begin
        if (reset) begin
            r_mode <= MODE_SCAN;
            r_leds <= SCAN_START;
            r_up   <= 1'b1;
        end else begin
            r_mode <= w_mode_nxt;
            r_leds <= w_leds_nxt;
            r_up   <= w_up_nxt;
        end
    end

    // A press pre-empts a coincident tick, so no step is shown that cycle.
    assign step = w_tick & ~w_press;
    assign LEDS = r_leds;
    assign mode = r_mode;
endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: randomized button stimulus scored cycle by cycle against a sequence-table model.
module tb_led_mode_ctrl;
    localparam int TD = 4;
    localparam int DB = 8;
    localparam logic [7:0] SCAN_SEQ [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                            8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
    localparam logic [7:0] FILL_SEQ [9]  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};

    typedef struct packed {
        logic [1:0] md;
        logic [7:0] leds;
        logic       stp;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       USER_BTN;
    logic [7:0] LEDS;
    logic [1:0] mode;
    logic       step;
    int         errors = 0;
    int         checks = 0;
    exp_t       exp_q[$];
    bit         hist[$];
    bit         fh[$];
    int         m_mode, m_idx, m_t, m_n;

    led_mode_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
        .CLK12M   (clk),
        .reset    (reset),
        .USER_BTN (USER_BTN),
        .LEDS     (LEDS),
        .mode     (mode),
        .step     (step)
    );

    always #5 clk = ~clk;

    // b_at(j): button level sampled on the j-th edge after reset; released before that.
    function automatic bit b_at(int j);
        return j < 1 ? 1'b1 : hist[j-1];
    endfunction
    // f_at(m): filtered button level after the m-th edge after reset.
    function automatic bit f_at(int m);
        return m < 1 ? 1'b1 : fh[m-1];
    endfunction
    function automatic bit armed_at(int x);
        for (int j = 1; j <= x - 2; j++)
            if (b_at(j)) return 1'b1;
        return 1'b0;
    endfunction
    function automatic bit next_f(int m);
`ifdef USER_BTN_DEBOUNCE_EN
        for (int j = m - DB - 1; j <= m - 2; j++)
            if (b_at(j) == f_at(m - 1)) return f_at(m - 1);
        return !f_at(m - 1);
`else
        return b_at(m - 1);
`endif
    endfunction
    function automatic logic [7:0] pat(int md, int i);
        case (md)
            0: return SCAN_SEQ[i % 14];
            1: return FILL_SEQ[i % 9];
            2: return (i % 2) != 0 ? 8'hAA : 8'h55;
            default: return 8'h00;
        endcase
    endfunction

    // Reference model: one expected output set per rising edge.
    initial forever begin
        bit pr, nxt;
        @(posedge clk);
        nxt = 1'b0;
        if (reset) begin
            m_mode = 0;
            m_idx = 0;
            m_t = 0;
            m_n = 0;
            hist.delete();
            fh.delete();
        end else begin
            m_n++;
            pr = armed_at(m_n - 1) && f_at(m_n - 2) && !f_at(m_n - 1);
            hist.push_back(USER_BTN);
            fh.push_back(next_f(m_n));
            if (pr) begin
                m_mode = (m_mode + 1) % 4;
                m_idx = 0;
                m_t = 0;
            end else if (m_t == TD - 1) begin
                m_idx++;
                m_t = 0;
            end else begin
                m_t++;
            end
            nxt = armed_at(m_n) && f_at(m_n - 1) && !f_at(m_n);
        end
        exp_q.push_back({2'(m_mode), pat(m_mode, m_idx), (m_t == TD - 1) && !nxt});
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: no expected entry at %0t, required one per edge", $time);
        end else begin
            e = exp_q.pop_front();
            if ({mode, LEDS, step} !== e) begin
                errors++;
                $display("FAIL outputs @%0t: mode/leds/step got %0d/%h/%0d required %0d/%h/%0d",
                         $time, mode, LEDS, step, e.md, e.leds, e.stp);
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask
    task automatic press(input int lo, input int hi);
        USER_BTN = 1'b0;
        cyc(lo);
        USER_BTN = 1'b1;
        cyc(hi);
    endtask

    initial begin
        int k;
        reset = 1'b1;
        USER_BTN = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(64);
        press(2, 30);
        press(5, 30);
        press(12, 40);
        repeat (8) press(12, 20 + $urandom_range(0, 7));
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(5);
        press(12, 0);
        for (k = 0; k < 200 && !(m_mode == 1 && m_idx % 9 == 4); k++) cyc(1);
        checks++;
        if (k >= 200) begin
            errors++;
            $display("FAIL reach_fill_1f: model mode/idx %0d/%0d after %0d cycles, required 1/4", m_mode, m_idx % 9, k);
        end
        USER_BTN = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(40);
        USER_BTN = 1'b1;
        cyc(20);
        press(12, 30);
        repeat (60) begin
            press($urandom_range(1, 14), $urandom_range(1, 30));
            if ($urandom_range(0, 14) == 0) begin
                reset = 1'b1;
                cyc($urandom_range(1, 2));
                reset = 1'b0;
            end
        end
        cyc(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
